// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-setting controller for a clock display.
// Two debounced buttons step through hour/minute/second edit states. The
// up button increments the selected field. The commit state pulses load
// so the timekeeper takes over the edited time.
// Optional feature macro: TIME_SET_AUTOREPEAT_EN (auto-repeat on held up button).
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BLINK_CYCLES    = 25000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       setting,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    // Zero-length timing parameters would underflow the terminal counts.
    if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("time_set_ctrl: all cycle parameters must be at least 1");
    end

    // Index 0 is the mode button, index 1 is the up button.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_deb;
    logic [1:0]      r_deb_q;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_set_hour, w_hour_nxt;
    logic [5:0]      r_set_min,  w_min_nxt;
    logic [5:0]      r_set_sec,  w_sec_nxt;
    logic            r_load, r_setting, r_blink, w_blink_nxt;
    logic [1:0]      r_field_sel;
    logic [BL_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic            w_inc;

    logic            w_mode_ev;
    logic            w_up_press;
    logic            w_up_ev;
    logic            w_in_set;

    assign w_mode_ev  = r_deb[0] & ~r_deb_q[0];
    assign w_up_press = r_deb[1] & ~r_deb_q[1];
    assign w_in_set   = (r_state == SET_HOUR) || (r_state == SET_MIN) || (r_state == SET_SEC);

    // Synchronize both buttons and accept a new level only after it stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_deb    <= 2'b00;
            r_deb_q  <= 2'b00;
            r_db_cnt <= '{default: '0};
        end else begin
            r_sync1 <= {btn_up, btn_mode};
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_deb[i]    <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] r_rep_cnt;
    logic            r_rep_phase;
    logic            w_rep_ev;

    // A repeat fires after the initial hold delay, then at the faster interval.
    always_comb begin
        w_rep_ev = 1'b0;
        if (r_deb[1] && w_in_set && !w_up_press) begin
            if (r_rep_phase) begin
                w_rep_ev = (r_rep_cnt == RP_W'(REPEAT_CYCLES - 1));
            end else begin
                w_rep_ev = (r_rep_cnt == RP_W'(REPEAT_DELAY - 1));
            end
        end else begin
            w_rep_ev = 1'b0;
        end
    end

    // Hold-time counter restarts on each press and clears on release or outside edits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (!r_deb[1] || !w_in_set || w_up_press) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_ev) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + RP_W'(1);
        end
    end

    assign w_up_ev = w_up_press | w_rep_ev;
`else
    assign w_up_ev = w_up_press;
`endif

    // Next state and edited values; a mode event always beats an up event.
    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_set_hour;
        w_min_nxt   = r_set_min;
        w_sec_nxt   = r_set_sec;
        w_inc       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mode_ev) begin
                    w_state_nxt = SET_HOUR;
                    w_hour_nxt  = cur_hour;
                    w_min_nxt   = cur_min;
                    w_sec_nxt   = cur_sec;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            SET_HOUR: begin
                if (w_mode_ev) begin
                    w_state_nxt = SET_MIN;
                end else if (w_up_ev) begin
                    w_hour_nxt = (r_set_hour >= 5'd23) ? 5'd0 : r_set_hour + 5'd1;
                    w_inc      = 1'b1;
                end else begin
                    w_state_nxt = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (w_mode_ev) begin
                    w_state_nxt = SET_SEC;
                end else if (w_up_ev) begin
                    w_min_nxt = (r_set_min >= 6'd59) ? 6'd0 : r_set_min + 6'd1;
                    w_inc     = 1'b1;
                end else begin
                    w_state_nxt = SET_MIN;
                end
            end
            SET_SEC: begin
                if (w_mode_ev) begin
                    w_state_nxt = COMMIT;
                end else if (w_up_ev) begin
                    w_sec_nxt = (r_set_sec >= 6'd59) ? 6'd0 : r_set_sec + 6'd1;
                    w_inc     = 1'b1;
                end else begin
                    w_state_nxt = SET_SEC;
                end
            end
            COMMIT:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Blink restarts high on entering a field or editing it, then toggles at the half-period.
    always_comb begin
        w_blink_nxt     = 1'b1;
        w_blink_cnt_nxt = '0;
        if (w_state_nxt == RUN || w_state_nxt == COMMIT) begin
            w_blink_nxt     = 1'b1;
            w_blink_cnt_nxt = '0;
        end else if (w_state_nxt != r_state || w_inc) begin
            w_blink_nxt     = 1'b1;
            w_blink_cnt_nxt = '0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            w_blink_nxt     = ~r_blink;
            w_blink_cnt_nxt = '0;
        end else begin
            w_blink_nxt     = r_blink;
            w_blink_cnt_nxt = r_blink_cnt + BL_W'(1);
        end
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_set_hour  <= 5'd0;
            r_set_min   <= 6'd0;
            r_set_sec   <= 6'd0;
            r_load      <= 1'b0;
            r_setting   <= 1'b0;
            r_field_sel <= 2'b00;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_set_hour  <= w_hour_nxt;
            r_set_min   <= w_min_nxt;
            r_set_sec   <= w_sec_nxt;
            r_load      <= (w_state_nxt == COMMIT);
            r_setting   <= (w_state_nxt != RUN);
            r_blink     <= w_blink_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            case (w_state_nxt)
                SET_HOUR: r_field_sel <= 2'b01;
                SET_MIN:  r_field_sel <= 2'b10;
                SET_SEC:  r_field_sel <= 2'b11;
                default:  r_field_sel <= 2'b00;
            endcase
        end
    end

    assign set_hour  = r_set_hour;
    assign set_min   = r_set_min;
    assign set_sec   = r_set_sec;
    assign load      = r_load;
    assign setting   = r_setting;
    assign field_sel = r_field_sel;
    assign blink     = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic [4:0] cur_hour = 5'd13;
    logic [5:0] cur_min = 6'd45;
    logic [5:0] cur_sec = 6'd7;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load;
    logic       setting;
    logic [1:0] field_sel;
    logic       blink;

    int n_chk = 0;
    int n_err = 0;
    int load_cycles = 0;
    int load_h = 0;
    int load_m = 0;
    int load_s = 0;
    int tog [3];
    int n_tog;
    logic prev_blink;
    int exp_rep_min;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES(8),
        .REPEAT_DELAY(16),
        .REPEAT_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .load(load), .setting(setting), .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    // Record every cycle load is high and the values it carries.
    always @(negedge clk) begin
        if (load) begin
            load_cycles = load_cycles + 1;
            load_h = int'(set_hour);
            load_m = int'(set_min);
            load_s = int'(set_sec);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 mode, 1 up, 2 both together
    task automatic press(input int which, input int hold);
        if (which == 0) begin
            btn_mode = 1'b1;
        end else if (which == 1) begin
            btn_up = 1'b1;
        end else begin
            btn_mode = 1'b1;
            btn_up   = 1'b1;
        end
        tick(hold);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(10);
    endtask

    initial begin
        tick(3);
        check_eq("rst_hour", set_hour, 0);
        check_eq("rst_min", set_min, 0);
        check_eq("rst_sec", set_sec, 0);
        check_eq("rst_load", load, 0);
        check_eq("rst_setting", setting, 0);
        check_eq("rst_field", field_sel, 0);
        check_eq("rst_blink", blink, 1);
        rst = 1'b0;
        tick(2);

        // Short glitch is filtered.
        press(0, 2);
        check_eq("glitch_setting", setting, 0);
        check_eq("glitch_field", field_sel, 0);

        // Up press in RUN is ignored.
        press(1, 10);
        check_eq("run_up_ignored", set_hour, 0);

        // Enter SET_HOUR capturing 13:45:07.
        press(0, 10);
        check_eq("enter_field", field_sel, 1);
        check_eq("enter_setting", setting, 1);
        check_eq("enter_hour", set_hour, 13);
        check_eq("enter_min", set_min, 45);
        check_eq("enter_sec", set_sec, 7);

        // Blink half-period of 8 cycles.
        n_tog = 0;
        tog = '{0, 0, 0};
        prev_blink = blink;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (blink != prev_blink && n_tog < 3) begin
                tog[n_tog] = i;
                n_tog++;
            end
            prev_blink = blink;
        end
        check_eq("blink_toggle_count", n_tog, 3);
        check_eq("blink_period_a", tog[1] - tog[0], 8);
        check_eq("blink_period_b", tog[2] - tog[1], 8);

        // Increment forces blink high and restarts its count.
        btn_up = 1'b1;
        tick(7);
        check_eq("inc_hour_14", set_hour, 14);
        check_eq("inc_blink_hi", blink, 1);
        btn_up = 1'b0;
        tick(7);
        check_eq("inc_blink_still_hi", blink, 1);
        tick(1);
        check_eq("inc_blink_toggled", blink, 0);
        tick(8);

        for (int i = 0; i < 9; i++) press(1, 6);
        check_eq("hour_23", set_hour, 23);
        press(1, 6);
        check_eq("hour_wrap", set_hour, 0);

        press(0, 10);
        check_eq("min_field", field_sel, 2);

        // Simultaneous mode and up: mode wins.
        press(2, 10);
        check_eq("coinc_field", field_sel, 3);
        check_eq("coinc_min", set_min, 45);

        for (int i = 0; i < 52; i++) press(1, 6);
        check_eq("sec_59", set_sec, 59);
        press(1, 6);
        check_eq("sec_wrap", set_sec, 0);
        check_eq("sec_wrap_min", set_min, 45);

        // Commit.
        load_cycles = 0;
        press(0, 10);
        check_eq("load_once", load_cycles, 1);
        check_eq("load_hour", load_h, 0);
        check_eq("load_min", load_m, 45);
        check_eq("load_sec", load_s, 0);
        check_eq("commit_setting", setting, 0);
        check_eq("commit_field", field_sel, 0);
        check_eq("run_hold_min", set_min, 45);

        // Reset in SET_MIN abandons the edit.
        press(0, 10);
        press(0, 10);
        check_eq("pre_rst_field", field_sel, 2);
        load_cycles = 0;
        rst = 1'b1;
        #1;
        check_eq("arst_field", field_sel, 0);
        check_eq("arst_setting", setting, 0);
        check_eq("arst_hour", set_hour, 0);
        check_eq("arst_min", set_min, 0);
        check_eq("arst_blink", blink, 1);
        check_eq("arst_load", load, 0);
        // Button held across reset release.
        cur_min = 6'd10;
        btn_mode = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(12);
        check_eq("no_load_after_rst", load_cycles, 0);
        check_eq("held_btn_event", field_sel, 1);
        btn_mode = 1'b0;
        tick(10);
        check_eq("held_release_no_event", field_sel, 1);

        press(0, 10);
        check_eq("rep_field", field_sel, 2);
        check_eq("rep_start_min", set_min, 10);

        // Up held 40 debounced cycles.
        btn_up = 1'b1;
        tick(40);
        btn_up = 1'b0;
        tick(12);
`ifdef TIME_SET_AUTOREPEAT_EN
        exp_rep_min = 17;
`else
        exp_rep_min = 11;
`endif
        check_eq("hold_up_min", set_min, exp_rep_min);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
